instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot loader: parses a framed byte stream (sync, count, words, checksum), writes each
// 16-bit word into the instruction RAM and releases the CPU once the checksum verifies.
module instr_loader #(
   parameter int         TIMEOUT   = 1024,
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        error
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         TW        = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {SYNC, COUNT, HI, LO, CHECK, DONE, ERR} state_t;

   state_t        state_q;
   logic [7:0]    cnt_q;
   logic [7:0]    idx_q;
   logic [7:0]    sum_q;
   logic [7:0]    hi_q;
   logic [TW-1:0] tmo_q;

   logic          in_ready_q;
   logic          mem_we_q;
   logic [7:0]    mem_addr_q;
   logic [15:0]   mem_wdata_q;
   logic          cpu_rst_q;
   logic          done_q;
   logic          error_q;

   logic          xfer;
   logic          in_frame;
   logic          tmo_hit;
   logic [7:0]    idx_d;
   logic [7:0]    sum_d;

   // The timeout fires on the TIMEOUT-th consecutive idle cycle inside a frame.
   always_comb begin
      xfer     = in_valid && in_ready_q;
      in_frame = state_q inside {COUNT, HI, LO, CHECK};
      tmo_hit  = in_frame && !xfer && (tmo_q == TW'(TIMEOUT - 1));
      idx_d    = idx_q + 8'd1;
      sum_d    = sum_q + in_data;
   end

   // NOTE: rst is tested first so it overrides any handshake landing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SYNC;
         cnt_q       <= 8'd0;
         idx_q       <= 8'd0;
         sum_q       <= 8'd0;
         hi_q        <= 8'd0;
         tmo_q       <= '0;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= 16'd0;
         cpu_rst_q   <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;

         if (xfer || !in_frame) tmo_q <= '0;
         else                   tmo_q <= tmo_q + TW'(1);

         if (tmo_hit) begin
            state_q <= ERR;
            error_q <= 1'b1;
         end else if (xfer) begin
            case (state_q)
               SYNC: begin
                  if (in_data == SYNC_BYTE) state_q <= COUNT;
               end
               COUNT: begin
                  if (in_data == 8'd0) begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= HI;
                     cnt_q   <= in_data;
                     idx_q   <= 8'd0;
                     sum_q   <= in_data;
                  end
               end
               HI: begin
                  hi_q    <= in_data;
                  sum_q   <= sum_d;
                  state_q <= LO;
               end
               LO: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= BASE_ADDR + idx_q;
                  mem_wdata_q <= {hi_q, in_data};
                  sum_q       <= sum_d;
                  idx_q       <= idx_d;
                  state_q     <= (idx_d == cnt_q) ? CHECK : HI;
               end
               CHECK: begin
                  if (sum_d == 8'd0) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     cpu_rst_q  <= 1'b0;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
               ERR: begin
                  if (in_data == SYNC_BYTE) begin
                     state_q <= COUNT;
                     error_q <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: fixed vector table, hand sequences for timeout and
// mid-frame reset, and random frames checked against a frame-level reference model.
module tb_instr_loader;

   localparam int         TB_TMO  = 100;
   localparam logic [7:0] TB_BASE = 8'hF0;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   logic [23:0] wr_q[$];
   logic [15:0] frame_words[$];

   typedef struct {
      bit          do_rst;
      int          n;
      logic [7:0]  b[8];
      int          exp_wr;
      logic [15:0] exp_w0;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t vecs[5];

   instr_loader #(.TIMEOUT(TB_TMO), .BASE_ADDR(TB_BASE)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_we) wr_q.push_back({mem_addr, mem_wdata});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},  in_ready,  1);
      check({tag, "_mem_we"},    mem_we,    0);
      check({tag, "_mem_addr"},  mem_addr,  TB_BASE);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_cpu_rst"},   cpu_rst,   1);
      check({tag, "_done"},      done,      0);
      check({tag, "_error"},     error,     0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      wr_q.delete();
   endtask

   // Presents a byte; the handshake happens on the posedge after in_ready is seen high.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: byte %0h never accepted", b);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int k);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (k) @(negedge clk);
   endtask

   // Reference model: frame bytes are built from the word list, pass/fail is decided by the
   // mod-256 sum of everything after the sync byte, and word i lands at (BASE + i) mod 256.
   task automatic run_frame(input bit corrupt, input int maxgap, input string tag);
      logic [7:0] bytes[$];
      int         total;
      int         n;
      bit         exp_ok;
      logic [7:0] cks;
      n = frame_words.size();
      total = n;
      bytes.push_back(8'hA5);
      bytes.push_back(8'(n));
      foreach (frame_words[i]) begin
         bytes.push_back(frame_words[i][15:8]);
         bytes.push_back(frame_words[i][7:0]);
         total += frame_words[i][15:8] + frame_words[i][7:0];
      end
      cks = 8'((256 - (total % 256)) % 256);
      if (corrupt) cks = cks + 8'd1;
      bytes.push_back(cks);
      exp_ok = ((total + cks) % 256) == 0;

      foreach (bytes[i]) begin
         int g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
         if (g > 0) idle(g);
         send_byte(bytes[i]);
      end
      idle(3);

      check({tag, "_nwrites"}, wr_q.size(), n);
      for (int i = 0; i < n && i < wr_q.size(); i++)
         check($sformatf("%s_write%0d", tag, i), wr_q[i], {8'(TB_BASE + i), frame_words[i]});
      check({tag, "_hold_addr"},  mem_addr,  8'(TB_BASE + n - 1));
      check({tag, "_hold_data"},  mem_wdata, frame_words[n-1]);
      check({tag, "_done"},       done,      exp_ok);
      check({tag, "_error"},      error,     !exp_ok);
      check({tag, "_cpu_rst"},    cpu_rst,   !exp_ok);
      check({tag, "_in_ready"},   in_ready,  !exp_ok);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;

      vecs[0] = '{1'b1, 7, '{8'h00, 8'h13, 8'hA5, 8'h01, 8'h12, 8'h34, 8'hB9, 8'h00},
                  1, 16'h1234, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5, '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 16'h1234, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 5, '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hB9, 8'h00, 8'h00, 8'h00},
                  1, 16'h1234, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 2, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 16'h0000, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 7, '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54, 8'h00},
                  2, 16'h1122, 1'b1, 1'b0};

      do_reset();

      for (int r = 0; r < 5; r++) begin
         if (vecs[r].do_rst) do_reset();
         wr_q.delete();
         for (int i = 0; i < vecs[r].n; i++) send_byte(vecs[r].b[i]);
         idle(3);
         check($sformatf("vec%0d_nwrites", r), wr_q.size(), vecs[r].exp_wr);
         if (vecs[r].exp_wr > 0 && wr_q.size() > 0)
            check($sformatf("vec%0d_write0", r), wr_q[0], {TB_BASE, vecs[r].exp_w0});
         check($sformatf("vec%0d_done", r),     done,     vecs[r].exp_done);
         check($sformatf("vec%0d_error", r),    error,    vecs[r].exp_err);
         check($sformatf("vec%0d_cpu_rst", r),  cpu_rst,  !vecs[r].exp_done);
         check($sformatf("vec%0d_in_ready", r), in_ready, !vecs[r].exp_done);
      end

      // Eight-word program loaded back to back, then done must stay sticky.
      do_reset();
      frame_words = '{16'h1005, 16'h1107, 16'h2201, 16'h3200,
                      16'h4000, 16'h5000, 16'h0000, 16'hF000};
      run_frame(1'b0, 0, "prog8");
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check("sticky_done",     done,        1);
      check("sticky_in_ready", in_ready,    0);
      check("sticky_nwrites",  wr_q.size(), 8);

      // Idle timeout inside a frame, one cycle before and at the limit.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h11);
      idle(TB_TMO - 1);
      check("tmo_before_error", error, 0);
      @(negedge clk);
      check("tmo_error",   error,       1);
      check("tmo_cpu_rst", cpu_rst,     1);
      check("tmo_ready",   in_ready,    1);
      check("tmo_nwrites", wr_q.size(), 0);

      // Reset while in LO with a byte presented in the same cycle.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      @(negedge clk);
      in_data  = 8'h22;
      in_valid = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("midrst_nwrites", wr_q.size(), 0);
      frame_words = '{16'hABCD, 16'h0102, 16'hFFEE};
      run_frame(1'b0, 2, "after_rst");

      // Random frames, some with a corrupted checksum.
      for (int k = 0; k < 6; k++) begin
         int n;
         do_reset();
         frame_words.delete();
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
         run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 4), $sformatf("rnd%0d", k));
      end

      // Full 255-word frame with random gaps; addresses wrap past 8'hFF.
      do_reset();
      frame_words.delete();
      for (int i = 0; i < 255; i++) frame_words.push_back(16'($urandom));
      run_frame(1'b0, 20, "full255");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
